// File: rtl/series_ctx_pkg.sv
// Purpose: shared types and constants for the series context bank.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package series_ctx_pkg;

    localparam int X_W_DEF   = 8;
    localparam int N_W_DEF   = 4;
    localparam int Y_W_DEF   = 32;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Initial term value: MSB clear, every lower bit set, in a w-bit field.
    // Returned in 64 bits so callers can truncate to their own width (w <= 64).
    function automatic logic [63:0] t_init(input int w);
        logic [63:0] one;
        one    = 64'd1;
        t_init = (one << (w - 1)) - one;
    endfunction

endpackage

// File: rtl/series_job_fifo.sv
// Purpose: DEPTH-entry job queue holding {x, n} records in FIFO order.
// Latency: a push is visible at the head one cycle later; pop_dat is the head combinationally.
// Backpressure: full is high at DEPTH entries and ignores a same-cycle pop; pushes while full are dropped.
//
// Ports: push_vld/push_dat write side, pop_rdy/pop_dat read side, empty/full status.
module series_job_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/series_context_bank.sv
// Purpose: queues series jobs and holds the active job context while an external datapath steps it.
// Latency: push into an idle, empty block -> LOAD after 1 edge -> context loaded (RUN/DONE) after 2 edges.
// Backpressure: in_ready = queue not full; a finished result holds in DONE until out_ready.
//
// Ports: in_valid/in_ready/in_x/in_n job input; upd/upd_y/upd_t/upd_ovf datapath step;
//        out_y/out_t/out_x/out_n/out_ovf active context; out_valid/out_ready result handshake; busy.
// Build option: SERIES_CTX_OVF_SAT_EN saturates out_y on an overflow-terminated step.
module series_context_bank
    import series_ctx_pkg::*;
#(
    parameter int X_W   = X_W_DEF,
    parameter int N_W   = N_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] in_x,
    input  logic [N_W-1:0] in_n,
    input  logic           upd,
    input  logic [Y_W-1:0] upd_y,
    input  logic [Y_W-1:0] upd_t,
    input  logic           upd_ovf,
    output logic [Y_W-1:0] out_y,
    output logic [Y_W-1:0] out_t,
    output logic [X_W-1:0] out_x,
    output logic [N_W-1:0] out_n,
    output logic           out_ovf,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    localparam int             JOB_W  = X_W + N_W;
    localparam logic [Y_W-1:0] T_INIT = Y_W'(t_init(Y_W));

    state_t           state;
    logic             q_empty;
    logic             q_full;
    logic [JOB_W-1:0] q_head;
    logic [X_W-1:0]   head_x;
    logic [N_W-1:0]   head_n;
    logic             push_vld;
    logic             pop_rdy;
    logic             last_step;
    logic [Y_W-1:0]   next_y;

    assign in_ready         = !q_full;
    assign push_vld         = in_valid && in_ready;
    // The head is consumed during the single LOAD cycle; LOAD is only entered with a non-empty queue.
    assign pop_rdy          = (state == ST_LOAD);
    assign {head_x, head_n} = q_head;
    assign busy             = (state != ST_IDLE);
    assign last_step        = (out_n == N_W'(1)) || upd_ovf;

`ifdef SERIES_CTX_OVF_SAT_EN
    // Any overflowing step ends the job, so saturate exactly on upd_ovf.
    assign next_y = upd_ovf ? T_INIT : upd_y;
`else
    assign next_y = upd_y;
`endif

    series_job_fifo #(
        .W     (JOB_W),
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat ({in_x, in_n}),
        .pop_rdy  (pop_rdy),
        .pop_dat  (q_head),
        .empty    (q_empty),
        .full     (q_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            out_y     <= '0;
            out_t     <= '0;
            out_x     <= '0;
            out_n     <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!q_empty) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    out_x   <= head_x;
                    out_n   <= head_n;
                    out_y   <= '0;
                    out_t   <= T_INIT;
                    out_ovf <= 1'b0;
                    if (head_n == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (upd) begin
                        out_y   <= next_y;
                        out_t   <= upd_t;
                        out_ovf <= out_ovf | upd_ovf;
                        // RUN always exits at out_n == 1, but never let the counter wrap.
                        if (out_n != '0) out_n <= out_n - N_W'(1);
                        if (last_step) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= q_empty ? ST_IDLE : ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_series_context_bank.sv
// Purpose: self-checking bench for series_context_bank against a transaction-level job model.
// Latency: n/a.
// Backpressure: n/a.
module tb_series_context_bank;

    localparam int X_W   = 8;
    localparam int N_W   = 4;
    localparam int Y_W   = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] T_INIT = 32'h7FFF_FFFF;
    localparam logic [31:0] Y_SAT  = 32'h7FFF_FFFF;
`ifdef SERIES_CTX_OVF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [X_W-1:0] in_x;
    logic [N_W-1:0] in_n;
    logic           upd;
    logic [Y_W-1:0] upd_y;
    logic [Y_W-1:0] upd_t;
    logic           upd_ovf;
    logic [Y_W-1:0] out_y;
    logic [Y_W-1:0] out_t;
    logic [X_W-1:0] out_x;
    logic [N_W-1:0] out_n;
    logic           out_ovf;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    int vectors;
    int miscompares;

    series_context_bank #(
        .X_W(X_W), .N_W(N_W), .Y_W(Y_W), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_n      (in_n),
        .upd       (upd),
        .upd_y     (upd_y),
        .upd_t     (upd_t),
        .upd_ovf   (upd_ovf),
        .out_y     (out_y),
        .out_t     (out_t),
        .out_x     (out_x),
        .out_n     (out_n),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctx(input string tag, input logic [31:0] ey, input logic [31:0] et,
                             input logic [3:0] en, input logic eo, input logic ev);
        check({tag, "_y"}, 64'(out_y), 64'(ey));
        check({tag, "_t"}, 64'(out_t), 64'(et));
        check({tag, "_n"}, 64'(out_n), 64'(en));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        check({tag, "_valid"}, 64'(out_valid), 64'(ev));
    endtask

    task automatic check_zero(input string tag);
        check_ctx(tag, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        check({tag, "_x"}, 64'(out_x), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    // One job through an idle, empty block. The model follows the job's rules:
    // a load gives y=0, t=T_INIT; each accepted step takes the datapath values,
    // ORs overflow, and consumes one step; the job ends when steps run out or on overflow.
    task automatic run_job(input logic [7:0] x, input logic [3:0] n, input int ovf_step,
                           input bit seq_vals);
        logic [31:0] ey, et, uy, ut;
        logic [3:0]  en;
        logic        eo, ov, done;
        int          step;
        in_valid = 1'b1; in_x = x; in_n = n;
        tick();
        in_valid = 1'b0; in_x = 8'($urandom); in_n = 4'($urandom);
        check("push_edge_busy", 64'(busy), 64'h0);
        tick();
        check("load_busy", 64'(busy), 64'h1);
        check("load_valid", 64'(out_valid), 64'h0);
        tick();
        ey = 32'h0; et = T_INIT; en = n; eo = 1'b0; done = (n == 4'h0); step = 0;
        check("loaded_x", 64'(out_x), 64'(x));
        check_ctx("loaded", ey, et, en, eo, done);
        while (!done && step < 16) begin
            repeat ($urandom_range(0, 2)) begin
                upd = 1'b0; upd_y = $urandom; upd_t = $urandom; upd_ovf = 1'($urandom_range(0, 1));
                tick();
            end
            check_ctx("gap", ey, et, en, eo, 1'b0);
            uy = seq_vals ? 32'(step + 1) : $urandom;
            ut = $urandom;
            ov = (step + 1 == ovf_step);
            upd = 1'b1; upd_y = uy; upd_t = ut; upd_ovf = ov;
            tick();
            upd = 1'b0; upd_ovf = 1'b0;
            step++;
            et = ut;
            eo = eo | ov;
            en = en - 4'h1;
            ey = (SAT && ov) ? Y_SAT : uy;
            done = (en == 4'h0) || ov;
            check_ctx("step", ey, et, en, eo, done);
        end
        // Steps offered in DONE are ignored and the result holds.
        repeat (2) begin
            upd = 1'b1; upd_y = $urandom; upd_t = $urandom; upd_ovf = 1'b1;
            tick();
        end
        upd = 1'b0; upd_ovf = 1'b0;
        check_ctx("hold", ey, et, en, eo, 1'b1);
        check("hold_x", 64'(out_x), 64'(x));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'h0);
        check("release_busy", 64'(busy), 64'h0);
        check("release_in_ready", 64'(in_ready), 64'h1);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] hx;
        logic [3:0] rn;
        int         ostep;
        vectors = 0; miscompares = 0;
        in_valid = 0; in_x = 0; in_n = 0; upd = 0; upd_y = 0; upd_t = 0; upd_ovf = 0;
        out_ready = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check_zero("reset_async");
        tick();
        check_zero("reset_held");
        #2 rst = 1'b1;
        tick();
        check("reset_in_ready", 64'(in_ready), 64'h1);
        check_zero("idle_after_reset");

        // Three steps with y = 1, 2, 3 and no overflow.
        run_job(8'h05, 4'd3, 0, 1'b1);
        // Zero-step job goes straight to DONE.
        run_job(8'h3C, 4'd0, 0, 1'b1);
        // Overflow on the second of four steps.
        run_job(8'hA7, 4'd4, 2, 1'b1);
        // Random jobs.
        for (int j = 0; j < 14; j++) begin
            rn = 4'($urandom_range(0, 15));
            ostep = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (rn == 0) ? 1 : int'(rn)) : 0;
            run_job(8'($urandom), rn, ostep, 1'b0);
        end

        // Queue fill while the first job is running.
        in_valid = 1'b1; in_x = 8'h11; in_n = 4'd2;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("q_first_run_x", 64'(out_x), 64'h11);
        for (int k = 0; k < 4; k++) begin
            check("q_in_ready_open", 64'(in_ready), 64'h1);
            hx = 8'(8'hB0 + k);
            in_valid = 1'b1; in_x = hx; in_n = 4'd0;
            exp_q.push_back(hx);
            tick();
        end
        check("q_full_in_ready", 64'(in_ready), 64'h0);
        hx = 8'hBF;
        in_x = hx;
        tick();
        check("q_blocked_in_ready", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        upd = 1'b1; upd_y = 32'h55; upd_t = 32'h66; upd_ovf = 1'b0;
        tick();
        tick();
        upd = 1'b0;
        check("q_first_done", 64'(out_valid), 64'h1);
        check("q_done_in_ready", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b2b_valid_low", 64'(out_valid), 64'h0);
        check("b2b_busy", 64'(busy), 64'h1);
        check("b2b_prepop_in_ready", 64'(in_ready), 64'h0);
        tick();
        check("q_after_pop_in_ready", 64'(in_ready), 64'h1);
        check("b2b_x", 64'(out_x), 64'(exp_q.pop_front()));
        check("b2b_valid", 64'(out_valid), 64'h1);
        in_valid = 1'b1; in_x = hx; in_n = 4'd0;
        exp_q.push_back(hx);
        tick();
        in_valid = 1'b0;
        check("q_refill_in_ready", 64'(in_ready), 64'h0);
        while (exp_q.size() > 0) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("drain_valid_low", 64'(out_valid), 64'h0);
            check("drain_busy", 64'(busy), 64'h1);
            tick();
            check("drain_x", 64'(out_x), 64'(exp_q.pop_front()));
            check("drain_valid", 64'(out_valid), 64'h1);
            check("drain_y", 64'(out_y), 64'h0);
            check("drain_t", 64'(out_t), 64'(T_INIT));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_idle", 64'(busy), 64'h0);

        // Reset in RUN with two jobs waiting.
        in_valid = 1'b1; in_x = 8'h77; in_n = 4'd5;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_x = 8'h78; in_n = 4'd1;
        tick();
        in_x = 8'h79;
        tick();
        in_valid = 1'b0;
        upd = 1'b1; upd_y = 32'h1234; upd_t = 32'h5678;
        tick();
        upd = 1'b0;
        check("pre_rst_y", 64'(out_y), 64'h1234);
        #3 rst = 1'b0;
        #1 check_zero("mid_rst_async");
        check("mid_rst_in_ready", 64'(in_ready), 64'h1);
        #2 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_zero("post_rst_idle");
            check("post_rst_in_ready", 64'(in_ready), 64'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/series_context_bank.md
SERIES_CONTEXT_BANK -- requirements
Module: series_context_bank

Interface
REQ-001 X_W, default 8, operand x width.
REQ-002 N_W, default 4, term-count width.
REQ-003 Y_W, default 32, accumulator/term width.
REQ-004 DEPTH, default 4, job-queue entries; power of two, at least 2.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  job offered; in_ready  output  1  queue can accept.
REQ-008 in_x  input  X_W  operand; in_n  input  N_W  number of series steps.
REQ-009 upd  input  1  datapath step strobe; upd_y, upd_t  input  Y_W  next accumulator/term; upd_ovf  input  1  step overflowed.
REQ-010 out_y, out_t  output  Y_W; out_x  output  X_W; out_n  output  N_W  remaining steps (all active-context registers).
REQ-011 out_ovf  output  1  sticky overflow; out_valid  output  1  result ready; out_ready  input  1  result consumed; busy  output  1  state not IDLE.

Function
REQ-012 The queue SHALL accept a job on a rising edge with in_valid and in_ready both high, FIFO order; in_ready SHALL be high exactly when occupancy < DEPTH, independent of pops in the same cycle.
REQ-013 The FSM SHALL have states IDLE, LOAD, RUN, DONE; busy = (state != IDLE).
REQ-014 IDLE -> LOAD when the queue is non-empty; otherwise stay.
REQ-015 LOAD (one cycle) SHALL pop the head and load out_x=x, out_n=n, out_y=0, out_t=T_INIT ({1'b0, all ones}, Y_W bits), out_ovf=0; next state RUN, or DONE when n==0.
REQ-016 In RUN, upd SHALL load out_y=upd_y, out_t=upd_t, out_ovf|=upd_ovf, out_n-=1; transition to DONE when out_n==1 or upd_ovf; upd outside RUN SHALL be ignored.
REQ-017 In DONE, out_valid SHALL be 1 and all context outputs SHALL hold; out_ready high -> out_valid low on the next edge and state LOAD if the queue is non-empty, else IDLE.
REQ-018 Latency: push into an empty, idle block at edge 0 -> LOAD after edge 1 -> context loaded and RUN after edge 2.
REQ-019 out_n SHALL never wrap below zero; out_valid and out_ready may both stay high for one cycle only.

Reset
REQ-020 rst low SHALL asynchronously force: state IDLE, queue empty, out_y=0, out_t=0, out_x=0, out_n=0, out_ovf=0, out_valid=0; in_ready=1 once rst is released.
REQ-021 Reset mid-job or with a non-empty queue SHALL discard all pending and active work.

Configuration
REQ-022 SERIES_CTX_OVF_SAT_EN defined: a RUN->DONE transition caused by upd_ovf SHALL load out_y={1'b0, all ones} instead of upd_y.
REQ-023 SERIES_CTX_OVF_SAT_EN undefined: out_y SHALL take upd_y unconditionally; out_ovf behaviour is identical in both builds.

Structure
REQ-024 Package series_ctx_pkg SHALL hold the FSM state typedef, default width constants and the T_INIT constant function.
REQ-025 The queue SHALL be the sub-module series_job_fifo (DEPTH x (X_W+N_W)); the FSM and context registers stay in the top.

Verification
REQ-026 Reset then push x=8'h05, n=3; three upd pulses with upd_y=1,2,3 -> DONE, out_y=3, out_n=0, out_ovf=0, out_valid=1.
REQ-027 Push n=0 -> LOAD then DONE directly; out_y=0, out_t=32'h7FFF_FFFF.
REQ-028 Push 5 jobs with out_ready low -> in_ready low after fourth accepted while first job runs; fifth accepted only after the first pop.
REQ-029 n=4, second upd with upd_ovf=1 -> DONE, out_n=2, out_ovf=1; out_y=32'h7FFF_FFFF with SERIES_CTX_OVF_SAT_EN, else upd_y.
REQ-030 Back-to-back jobs, out_ready pulsed in DONE -> next job LOAD on the following edge with out_valid low.
REQ-031 Assert rst low during RUN with two queued jobs -> all outputs zero, busy low, in_ready high, no queued job resumes.
